// File: rtl/cache_pkg.sv
// Shared parameters, address slicing helpers and FSM state type for the
// instruction-cache refill controller.
package cache_pkg;

  localparam int TAG_W  = 24;
  localparam int SET_W  = 3;
  localparam int WAYS   = 8;
  localparam int BEATS  = 8;
  localparam int WORD_W = 32;
  localparam int WIDX_W = 3;
  localparam int SETS   = 1 << SET_W;
  localparam int LINE_W = BEATS * WORD_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_WRITE
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:8];
  endfunction

  function automatic logic [SET_W-1:0] addr_set(input logic [31:0] addr);
    return addr[7:5];
  endfunction

  function automatic logic [WIDX_W-1:0] addr_word(input logic [31:0] addr);
    return addr[4:2];
  endfunction

endpackage

// File: rtl/decoder3to8.sv
// Plain 3-to-8 binary to one-hot decoder.
module decoder3to8 (
  input  logic [2:0] sel_i,
  output logic [7:0] onehot_o
);

  assign onehot_o = 8'b0000_0001 << sel_i;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-handling and line-fill controller for the 8-set x 8-way instruction cache.
// Define CACHE_REFILL_CRIT_WORD_FIRST_EN for critical-word-first bursts with early restart.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  input  logic              hit,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [WORD_W-1:0] mem_rsp_data,
  output logic              fill_we,
  output logic [SETS-1:0]   fill_set_oh,
  output logic [WAYS-1:0]   fill_way_oh,
  output logic [TAG_W-1:0]  fill_tag,
  output logic [LINE_W-1:0] fill_data,
  output logic              crit_valid,
  output logic [WORD_W-1:0] crit_data
);

  state_e                       state_q, state_d;
  logic [31:2]                  addr_q, addr_d;
  logic [WIDX_W-1:0]            cnt_q, cnt_d;
  logic [BEATS-1:0][WORD_W-1:0] line_q, line_d;
  logic [SETS-1:0][WIDX_W-1:0]  victim_q, victim_d;

  logic [31:0]       line_addr;
  logic [SET_W-1:0]  set_idx;
  logic [WIDX_W-1:0] start_idx;
  logic [WIDX_W-1:0] beat_idx;
  logic [SETS-1:0]   set_dec;
  logic [WAYS-1:0]   way_dec;
  logic              in_fill_or_write;
  logic              first_beat;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  assign line_addr = {addr_q, 2'b00};
  assign set_idx   = addr_set(line_addr);
  assign beat_idx  = start_idx + cnt_q;
  assign first_beat = (state_q == S_FILL) && mem_rsp_valid && (cnt_q == '0);

`ifdef CACHE_REFILL_CRIT_WORD_FIRST_EN
  assign start_idx = addr_word(line_addr);
`else
  assign start_idx = '0;
`endif

  decoder3to8 u_set_dec (
    .sel_i    (set_idx),
    .onehot_o (set_dec)
  );

  decoder3to8 u_way_dec (
    .sel_i    (victim_q[set_idx]),
    .onehot_o (way_dec)
  );

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    victim_d = victim_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !hit) begin
          addr_d  = req_addr[31:2];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_rsp_valid) begin
          line_d[beat_idx] = mem_rsp_data;
          cnt_d            = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        victim_d[set_idx] = victim_q[set_idx] + 3'd1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the victim pointers and line buffer are small register arrays, not
  // RAM, so they take the async reset like any other state.
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge value of every other.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      line_q   <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      victim_q <= victim_d;
    end
  end

  assign in_fill_or_write = (state_q == S_FILL) || (state_q == S_WRITE);

  assign stall         = (state_q != S_IDLE) || (req_valid && !hit);
  assign mem_req_valid = (state_q == S_REQ);
  assign fill_we       = (state_q == S_WRITE);
  assign fill_set_oh   = in_fill_or_write ? set_dec : '0;
  assign fill_tag      = in_fill_or_write ? addr_tag(line_addr) : '0;
  assign fill_way_oh   = fill_we ? way_dec : '0;
  assign fill_data     = line_q;

`ifdef CACHE_REFILL_CRIT_WORD_FIRST_EN
  logic              crit_valid_q;
  logic [WORD_W-1:0] crit_data_q;

  // The first beat of a wrapped burst is the requested word: forward it for
  // early restart one cycle after it arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      crit_valid_q <= first_beat;
      crit_data_q  <= first_beat ? mem_rsp_data : '0;
    end
  end

  assign mem_req_addr = mem_req_valid ? line_addr : '0;
  assign crit_valid   = crit_valid_q;
  assign crit_data    = crit_data_q;
`else
  logic unused_first_beat;

  assign unused_first_beat = first_beat;
  assign mem_req_addr      = mem_req_valid ? {addr_q[31:5], 5'b0} : '0;
  assign crit_valid        = fill_we;
  assign crit_data         = fill_we ? line_q[addr_word(line_addr)] : '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed self-checking bench for cache_refill_ctrl (both macro builds).
module tb_cache_refill_ctrl;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         hit;
  logic         stall;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_data;
  logic         fill_we;
  logic [7:0]   fill_set_oh;
  logic [7:0]   fill_way_oh;
  logic [23:0]  fill_tag;
  logic [255:0] fill_data;
  logic         crit_valid;
  logic [31:0]  crit_data;

  int n_total = 0;
  int n_pass  = 0;

  cache_refill_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .hit           (hit),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .fill_we       (fill_we),
    .fill_set_oh   (fill_set_oh),
    .fill_way_oh   (fill_way_oh),
    .fill_tag      (fill_tag),
    .fill_data     (fill_data),
    .crit_valid    (crit_valid),
    .crit_data     (crit_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] model_line(input logic [31:0] addr, input logic [31:0] base);
    logic [255:0] l;
    logic [2:0]   start;
    logic [2:0]   w;
    l = '0;
`ifdef CACHE_REFILL_CRIT_WORD_FIRST_EN
    start = addr[4:2];
`else
    start = 3'd0;
`endif
    for (int k = 0; k < 8; k++) begin
      w = start + 3'(k);
      l[int'(w)*32 +: 32] = base + 32'(k);
    end
    return l;
  endfunction

  function automatic logic [31:0] model_req_addr(input logic [31:0] addr);
`ifdef CACHE_REFILL_CRIT_WORD_FIRST_EN
    return {addr[31:2], 2'b00};
`else
    return {addr[31:5], 5'b0};
`endif
  endfunction

  // One full miss: ready after rdy_wait REQ cycles, beats separated by gap idle
  // cycles, junk rsp driven in IDLE/REQ. Returns observations of the fill.
  task automatic run_miss(input logic [31:0] addr, input int rdy_wait, input int gap,
                          input logic [31:0] base,
                          output int n_stall, output int wr_cyc, output int cr_cyc,
                          output logic [31:0] cr_dat, output logic [7:0] set_oh,
                          output logic [7:0] way_oh, output logic [23:0] tag,
                          output logic [255:0] data, output int addr_bad);
    int req_cnt = 0;
    int beats   = 0;
    int idle    = 0;
    bit filling = 0;
    bit wrote   = 0;
    bit done    = 0;
    logic [31:0] exp_ra;
    exp_ra   = model_req_addr(addr);
    n_stall  = 0; wr_cyc = -1; cr_cyc = -1; cr_dat = '0;
    set_oh   = '0; way_oh = '0; tag = '0; data = '0; addr_bad = 0;
    req_addr = addr;
    req_valid = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      hit           = wrote;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
      if (mem_req_valid) begin
        if (mem_req_addr !== exp_ra) addr_bad++;
        if (req_cnt >= rdy_wait) begin
          mem_req_ready = 1'b1;
          filling       = 1'b1;
        end else begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = 32'hBAD0_0000 + 32'(req_cnt);
        end
        req_cnt++;
      end else if (filling && beats < 8) begin
        if (beats == 0 || idle >= gap) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = base + 32'(beats);
          beats++;
          idle = 0;
        end else begin
          idle++;
        end
      end else if (!filling) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBADF_FFFF;
      end
      #1;
      if (stall) n_stall++;
      if (crit_valid) begin
        cr_cyc = c;
        cr_dat = crit_data;
      end
      if (fill_we) begin
        wr_cyc = c;
        set_oh = fill_set_oh;
        way_oh = fill_way_oh;
        tag    = fill_tag;
        data   = fill_data;
        wrote  = 1'b1;
      end else if (wrote) begin
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("miss_completes", done, 1'b1);
    req_valid     = 1'b0;
    hit           = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
  endtask

  int           n_stall, wr_cyc, cr_cyc, addr_bad;
  logic [31:0]  cr_dat;
  logic [7:0]   set_oh, way_oh;
  logic [23:0]  tag;
  logic [255:0] data;
  logic [255:0] t1_line;
  logic [7:0]   exp_way;
  logic [31:0]  a;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; hit = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mem_req_addr", mem_req_addr, 32'h0);
    check("rst_fill_we", fill_we, 1'b0);
    check("rst_fill_set_oh", fill_set_oh, 8'h00);
    check("rst_fill_way_oh", fill_way_oh, 8'h00);
    check("rst_fill_data", fill_data, 256'h0);
    check("rst_crit_valid", crit_valid, 1'b0);
    req_valid = 1'b1; #1;
    check("rst_stall_follows_miss", stall, 1'b1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic miss at 0x1A4C, ideal memory
    run_miss(32'h0000_1A4C, 0, 0, 32'h1000, n_stall, wr_cyc, cr_cyc, cr_dat,
             set_oh, way_oh, tag, data, addr_bad);
    t1_line = model_line(32'h0000_1A4C, 32'h1000);
    check("t1_stall_len", n_stall, 11);
    check("t1_write_cycle", wr_cyc, 10);
    check("t1_fill_tag", tag, 24'h00001A);
    check("t1_fill_set_oh", set_oh, 8'h04);
    check("t1_fill_way_oh", way_oh, 8'h01);
    check("t1_fill_data", data, t1_line);
    check("t1_mem_req_addr", addr_bad, 0);
`ifdef CACHE_REFILL_CRIT_WORD_FIRST_EN
    check("t1_crit_cycle", cr_cyc, 3);
    check("t1_crit_data", cr_dat, 32'h1000);
`else
    check("t1_crit_cycle", cr_cyc, 10);
    check("t1_crit_data", cr_dat, 32'h1003);
`endif

    // Stray response in IDLE is ignored
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_rsp_buffer", fill_data, t1_line);
    check("idle_rsp_fill_we", fill_we, 1'b0);

    // Hit with req_valid, then no request
    req_addr = 32'h0000_1A4C; req_valid = 1'b1; hit = 1'b1; #1;
    check("hit_stall", stall, 1'b0);
    @(posedge clk); #1;
    check("hit_no_mem_req", mem_req_valid, 1'b0);
    req_valid = 1'b0; hit = 1'b0; #1;
    check("noreq_stall", stall, 1'b0);
    @(posedge clk); #1;
    check("noreq_no_mem_req", mem_req_valid, 1'b0);

    // Ready delayed 4 cycles, 2-cycle gaps between beats
    run_miss(32'h0000_56C8, 4, 2, 32'h2000, n_stall, wr_cyc, cr_cyc, cr_dat,
             set_oh, way_oh, tag, data, addr_bad);
    check("t4_stall_len", n_stall, 29);
    check("t4_write_cycle", wr_cyc, 28);
    check("t4_mem_req_addr_stable", addr_bad, 0);
    check("t4_fill_data", data, model_line(32'h0000_56C8, 32'h2000));
    check("t4_fill_set_oh", set_oh, 8'h40);
    check("t4_fill_tag", tag, 24'h000056);
`ifdef CACHE_REFILL_CRIT_WORD_FIRST_EN
    check("t4_crit_cycle", cr_cyc, 7);
    check("t4_crit_data", cr_dat, 32'h2000);
`else
    check("t4_crit_cycle", cr_cyc, 28);
    check("t4_crit_data", cr_dat, 32'h2002);
`endif

    // Reset during beat 5 of a burst to set 2
    req_addr = 32'h0000_3340; req_valid = 1'b1; hit = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h3000 + 32'(k);
      @(posedge clk); #1;
    end
    mem_rsp_data = 32'h3005; reset = 1'b0; #1;
    check("rst_mid_fill_data", fill_data, 256'h0);
    check("rst_mid_stall", stall, 1'b0);
    @(posedge clk); #1;
    check("rst_mid_fill_we", fill_we, 1'b0);
    check("rst_mid_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mid_fill_set_oh", fill_set_oh, 8'h00);
    reset = 1'b1;
    mem_rsp_data = 32'hBAD5_5555;
    repeat (2) @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    check("rst_stray_buffer", fill_data, 256'h0);
    check("rst_stray_fill_we", fill_we, 1'b0);
    check("rst_stray_stall", stall, 1'b0);
    run_miss(32'h0000_3340, 0, 0, 32'h3000, n_stall, wr_cyc, cr_cyc, cr_dat,
             set_oh, way_oh, tag, data, addr_bad);
    check("rst_new_miss_way", way_oh, 8'h01);
    check("rst_new_miss_data", data, model_line(32'h0000_3340, 32'h3000));

    // Fresh pointers, then nine misses to set 2 and one to set 5
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      a = {24'(i + 1), 3'd2, 5'd0};
      run_miss(a, 0, 0, 32'(i) << 8, n_stall, wr_cyc, cr_cyc, cr_dat,
               set_oh, way_oh, tag, data, addr_bad);
      exp_way = 8'h01 << (i % 8);
      check($sformatf("rr_way_%0d", i), way_oh, exp_way);
      check($sformatf("rr_tag_%0d", i), tag, 24'(i + 1));
    end
    run_miss({24'h0000AB, 3'd5, 5'd0}, 0, 0, 32'h5000, n_stall, wr_cyc, cr_cyc, cr_dat,
             set_oh, way_oh, tag, data, addr_bad);
    check("set5_way", way_oh, 8'h01);
    check("set5_set_oh", set_oh, 8'h20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-handling and line-fill controller that sits directly upstream of the 8-set × 8-way instruction cache array. On a lookup miss it stalls the fetch stage, fetches the 32-byte line from memory as eight 32-bit beats, assembles the 256-bit line, and writes it into a round-robin victim way of the indexed set. It drives the array's set-decode, way-select, tag and data write ports.

## Interface
- TAG_W, 24, tag width = addr[31:8]
- SET_W, 3, set index width = addr[7:5]
- WAYS, 8, ways per set
- BEATS, 8, 32-bit words per line; offset = addr[4:0], word index = addr[4:2]
- WORD_W, 32, memory beat width

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- req_valid  in  1  fetch lookup valid this cycle
- req_addr  in  32  fetch address (pcOut)
- hit  in  1  cache hit for req_addr, same cycle
- stall  out  1  fetch must hold req_addr
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  burst start address
- mem_rsp_valid  in  1  one beat valid
- mem_rsp_data  in  32  beat data
- fill_we  out  1  array write strobe (regWrite)
- fill_set_oh  out  8  one-hot set select
- fill_way_oh  out  8  one-hot victim way
- fill_tag  out  24  tag to write; valid bit set with write
- fill_data  out  256  assembled line, word i at bits [32i+31:32i]
- crit_valid  out  1  one-cycle pulse: requested word available
- crit_data  out  32  requested word

## Operation
- States: IDLE, REQ, FILL, WRITE.
- IDLE: req_valid & !hit → latch req_addr, → REQ. hit or !req_valid → stay.
- REQ: mem_req_valid=1, mem_req_addr held; on mem_req_ready → FILL, beat count=0.
- FILL: each mem_rsp_valid stores mem_rsp_data at word index (start + count) mod 8, count++; on 8th beat → WRITE.
- WRITE: fill_we=1 for exactly one cycle; fill_way_oh = decode(victim[set]); victim[set] increments, 7 wraps to 0; → IDLE.
- stall = (state != IDLE) | (req_valid & !hit) — combinational.
- hit/req_valid ignored outside IDLE; mem_rsp_valid ignored outside FILL; mem_req_ready ignored outside REQ.
- Victim pointers: eight 3-bit registers, one per set; only the filled set's pointer changes.
- Reset (any state, incl. mid-burst): state=IDLE, all victim pointers 0, line buffer 0; all outputs 0 except stall, which follows its equation (0 unless req_valid & !hit).

## Timing
- Miss detected cycle 0 (stall high, combinational); mem_req_valid from cycle 1.
- With ready in cycle 1 and back-to-back beats cycles 2–9: WRITE cycle 10, stall low cycle 11 (re-lookup hits). Minimum stall = 11 cycles; each wait cycle on ready/rsp adds one.
- fill_set_oh, fill_tag, fill_data stable from FILL through WRITE; registered outputs.
- mem_req_valid holds until ready; address must not change while valid.

## Configuration
- CACHE_REFILL_CRIT_WORD_FIRST_EN defined: mem_req_addr = {addr[31:2],2'b00}; burst start = addr[4:2], memory wraps 7→0; crit_valid pulses in cycle after first beat with that beat as crit_data (early restart; stall still held until after WRITE).
- Undefined: mem_req_addr = {addr[31:5],5'b0}; start = 0; crit_valid pulses in WRITE cycle with crit_data = word addr[4:2] of the line.

## Structure
- Package cache_pkg: TAG_W, SET_W, WAYS, BEATS, WORD_W, address slice functions (tag/set/word), state enum.
- Reuse existing decoder3to8 twice: set index → fill_set_oh, victim pointer → fill_way_oh. No new sub-module.

## Test plan
- Miss at 0x0000_1A4C, ready immediately, 8 beats 0x1000..0x1007 → WRITE cycle 10, fill_tag 0x00001A, fill_set_oh 0x04, fill_way_oh 0x01, crit_data = beat for word 3 (value 0x1003 off; with macro, first beat 0x1000 written to word 3, crit at cycle 3).
- Nine misses to set 2, different tags → fill_way_oh 0x01,0x02,…,0x80 then 0x01 (wrap); set 5 pointer stays 0.
- Hit with req_valid → no mem_req_valid, stall 0; req_valid=0 with hit=0 → stall 0.
- mem_req_ready low 4 cycles, rsp gaps of 2 cycles → mem_req_addr stable, beats placed correctly, stall length 11+4+14.
- reset low during beat 5 → next cycle state IDLE, fill_we 0, mem_req_valid 0; stray mem_rsp_valid afterwards ignored; new miss fills way 0.
- mem_rsp_valid asserted in IDLE/REQ → no buffer change, no fill.
